// File: rtl/uart_frame_decoder_if.sv
// Frame input and decoded-word output stream of the UART frame decoder.
// The master drives frames and consumes words; the slave is the decoder.
interface uart_frame_decoder_if #(
    parameter int DATA_W  = 8,
    parameter int FRAME_W = 11
);
    logic [FRAME_W-1:0] frame_in;
    logic               frame_valid;
    logic [DATA_W-1:0]  data_out;
    logic               data_valid;
    logic               data_ready;

    modport master (
        output frame_in,
        output frame_valid,
        output data_ready,
        input  data_out,
        input  data_valid
    );

    modport slave (
        input  frame_in,
        input  frame_valid,
        input  data_ready,
        output data_out,
        output data_valid
    );
endinterface

// File: rtl/uart_frame_decoder.sv
// UART frame checker/decoder: validates start, parity and stop bits of a
// fully shifted-in frame, reassembles the LSB-first data word, buffers good
// words in a small first-word-fall-through FIFO and keeps saturating
// error/overrun counters plus one-cycle status pulses.
module uart_frame_decoder #(
    parameter int DATA_W     = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_frame_decoder_if.slave           bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_ok,
    output logic                          parity_err,
    output logic                          framing_err,
    output logic                          overrun,
    output logic [CNT_W-1:0]              parity_cnt,
    output logic [CNT_W-1:0]              framing_cnt,
    output logic [CNT_W-1:0]              overrun_cnt,
    input  logic                          clr_cnt
);
    localparam int PAR_BITS = (PARITY != 0) ? 1 : 0;
    localparam int FRAME_W  = 1 + DATA_W + PAR_BITS + STOP_BITS;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = PTR_W + 1;

    // ------------------------------------------------------------------
    // Frame field extraction (first-received bit sits at the MSB)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]    data_word;
    logic                 start_bit;
    logic [STOP_BITS-1:0] stop_bits;
    logic                 framing_bad;
    logic                 parity_bad;

    assign start_bit = bus.frame_in[FRAME_W-1];
    assign stop_bits = bus.frame_in[STOP_BITS-1:0];

    // d0 follows the start bit, so data bit gi lives gi positions below it.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_data_bit
            assign data_word[gi] = bus.frame_in[FRAME_W-2-gi];
        end
    endgenerate

    assign framing_bad = start_bit | ~(&stop_bits);

    generate
        if (PARITY == 0) begin : g_no_parity
            assign parity_bad = 1'b0;
        end else begin : g_parity
            logic parity_bit;
            logic data_xor;
            assign parity_bit = bus.frame_in[STOP_BITS];
            assign data_xor   = ^data_word;
            if (PARITY == 1) begin : g_even
                assign parity_bad = (data_xor != parity_bit);
            end else begin : g_odd
                assign parity_bad = (data_xor == parity_bit);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic [LVL_W-1:0]  level_next;

    logic fifo_full;
    logic fifo_pop;
    logic frame_good;
    logic fifo_push;
    logic frame_drop;

    assign fifo_full  = (level_reg == LVL_W'(FIFO_DEPTH));
    // An empty FIFO cannot be popped, so data_ready is ignored then even
    // if a word is being pushed in the same cycle.
    assign fifo_pop   = (level_reg != '0) & bus.data_ready;
    assign frame_good = bus.frame_valid & ~framing_bad & ~parity_bad;
    // When full, a simultaneous pop frees the slot the push needs.
    assign fifo_push  = frame_good & (~fifo_full | fifo_pop);
    assign frame_drop = frame_good & ~fifo_push;

    // Next entry count from the push/pop pair.
    always_comb begin
        level_next = level_reg;
        case ({fifo_push, fifo_pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    // Storage: entries are cleared on reset so data_out reads 0 afterwards.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (rst) begin
                mem_reg[i] <= '0;
            end else if (fifo_push && (wr_ptr_reg == PTR_W'(i))) begin
                mem_reg[i] <= data_word;
            end
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            level_reg <= level_next;
        end
    end

    assign bus.data_out   = mem_reg[rd_ptr_reg];
    assign bus.data_valid = (level_reg != '0);
    assign fifo_level     = level_reg;

    // ------------------------------------------------------------------
    // Status pulses and saturating counters
    // ------------------------------------------------------------------
    logic             frame_ok_reg;
    logic             parity_err_reg;
    logic             framing_err_reg;
    logic             overrun_reg;
    logic [CNT_W-1:0] parity_cnt_reg;
    logic [CNT_W-1:0] framing_cnt_reg;
    logic [CNT_W-1:0] overrun_cnt_reg;

    logic parity_ev;
    logic framing_ev;

    assign parity_ev  = bus.frame_valid & parity_bad;
    assign framing_ev = bus.frame_valid & framing_bad;

    // One-cycle pulses for the frame seen at this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_ok_reg    <= 1'b0;
            parity_err_reg  <= 1'b0;
            framing_err_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            frame_ok_reg    <= fifo_push;
            parity_err_reg  <= parity_ev;
            framing_err_reg <= framing_ev;
            overrun_reg     <= frame_drop;
        end
    end

    // Counters stick at all-ones; a clear drops any coincident event.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            parity_cnt_reg  <= '0;
            framing_cnt_reg <= '0;
            overrun_cnt_reg <= '0;
        end else begin
            if (parity_ev && (parity_cnt_reg != '1))
                parity_cnt_reg <= parity_cnt_reg + CNT_W'(1);
            if (framing_ev && (framing_cnt_reg != '1))
                framing_cnt_reg <= framing_cnt_reg + CNT_W'(1);
            if (frame_drop && (overrun_cnt_reg != '1))
                overrun_cnt_reg <= overrun_cnt_reg + CNT_W'(1);
        end
    end

    assign frame_ok    = frame_ok_reg;
    assign parity_err  = parity_err_reg;
    assign framing_err = framing_err_reg;
    assign overrun     = overrun_reg;
    assign parity_cnt  = parity_cnt_reg;
    assign framing_cnt = framing_cnt_reg;
    assign overrun_cnt = overrun_cnt_reg;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder. Three instances: default even
// parity (a), 2-bit counters (b) and odd parity (c).
module tb_uart_frame_decoder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_frame_decoder_if #(.DATA_W(8), .FRAME_W(11)) if_a ();
    uart_frame_decoder_if #(.DATA_W(8), .FRAME_W(11)) if_b ();
    uart_frame_decoder_if #(.DATA_W(8), .FRAME_W(11)) if_c ();

    logic [2:0] lvl_a, lvl_b, lvl_c;
    logic       ok_a, ok_b, ok_c;
    logic       perr_a, perr_b, perr_c;
    logic       ferr_a, ferr_b, ferr_c;
    logic       ovr_a, ovr_b, ovr_c;
    logic [7:0] pcnt_a, fcnt_a, ocnt_a;
    logic [1:0] pcnt_b, fcnt_b, ocnt_b;
    logic [7:0] pcnt_c, fcnt_c, ocnt_c;
    logic       clr_a, clr_b, clr_c;

    uart_frame_decoder dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave), .fifo_level(lvl_a),
        .frame_ok(ok_a), .parity_err(perr_a), .framing_err(ferr_a),
        .overrun(ovr_a), .parity_cnt(pcnt_a), .framing_cnt(fcnt_a),
        .overrun_cnt(ocnt_a), .clr_cnt(clr_a)
    );

    uart_frame_decoder #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave), .fifo_level(lvl_b),
        .frame_ok(ok_b), .parity_err(perr_b), .framing_err(ferr_b),
        .overrun(ovr_b), .parity_cnt(pcnt_b), .framing_cnt(fcnt_b),
        .overrun_cnt(ocnt_b), .clr_cnt(clr_b)
    );

    uart_frame_decoder #(.PARITY(2)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c.slave), .fifo_level(lvl_c),
        .frame_ok(ok_c), .parity_err(perr_c), .framing_err(ferr_c),
        .overrun(ovr_c), .parity_cnt(pcnt_c), .framing_cnt(fcnt_c),
        .overrun_cnt(ocnt_c), .clr_cnt(clr_c)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Frames for data 0x01..0x05 (even parity, 1 stop), hand-encoded.
    logic [10:0] fill_frames [4] = '{11'h203, 11'h103, 11'h301, 11'h083};
    logic [7:0]  fill_data   [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0]  drain_data  [4] = '{8'h02, 8'h03, 8'h04, 8'h55};
    logic [1:0]  sat_exp     [4] = '{2'd1, 2'd2, 2'd3, 2'd3};

    initial begin
        rst = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        if_a.frame_in = '0; if_a.frame_valid = 1'b0; if_a.data_ready = 1'b0;
        if_b.frame_in = '0; if_b.frame_valid = 1'b0; if_b.data_ready = 1'b0;
        if_c.frame_in = '0; if_c.frame_valid = 1'b0; if_c.data_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("reset_level", 32'(lvl_a), 32'd0);
        chk("reset_valid", 32'(if_a.data_valid), 32'd0);
        chk("reset_data", 32'(if_a.data_out), 32'h00);
        chk("reset_pcnt", 32'(pcnt_a), 32'd0);
        chk("reset_ok", 32'(ok_a), 32'd0);

        // Test 1: good frame 0x295 -> 0xA5
        if_a.frame_in = 11'h295; if_a.frame_valid = 1'b1;
        tick();
        if_a.frame_valid = 1'b0;
        chk("t1_valid", 32'(if_a.data_valid), 32'd1);
        chk("t1_data", 32'(if_a.data_out), 32'hA5);
        chk("t1_ok", 32'(ok_a), 32'd1);
        chk("t1_perr", 32'(perr_a), 32'd0);
        chk("t1_level", 32'(lvl_a), 32'd1);
        if_a.data_ready = 1'b1;
        tick();
        if_a.data_ready = 1'b0;
        chk("t1_pop_level", 32'(lvl_a), 32'd0);
        chk("t1_pop_valid", 32'(if_a.data_valid), 32'd0);
        chk("t1_ok_pulse_end", 32'(ok_a), 32'd0);

        // Test 2: parity error, then stop and start errors back to back
        if_a.frame_in = 11'h297; if_a.frame_valid = 1'b1;
        tick();
        chk("t2_perr", 32'(perr_a), 32'd1);
        chk("t2_ferr_clear", 32'(ferr_a), 32'd0);
        chk("t2_pcnt", 32'(pcnt_a), 32'd1);
        chk("t2_level", 32'(lvl_a), 32'd0);
        if_a.frame_in = 11'h294;
        tick();
        chk("t2_stop_ferr", 32'(ferr_a), 32'd1);
        chk("t2_stop_perr", 32'(perr_a), 32'd0);
        if_a.frame_in = 11'h695;
        tick();
        if_a.frame_valid = 1'b0;
        chk("t2_start_ferr", 32'(ferr_a), 32'd1);
        chk("t2_fcnt", 32'(fcnt_a), 32'd2);
        chk("t2_no_write", 32'(lvl_a), 32'd0);
        chk("t2_no_valid", 32'(if_a.data_valid), 32'd0);

        // Test 3: fill the FIFO back to back, fifth frame overruns
        for (int i = 0; i < 4; i++) begin
            if_a.frame_in = fill_frames[i]; if_a.frame_valid = 1'b1;
            tick();
            chk($sformatf("t3_ok_%0d", i), 32'(ok_a), 32'd1);
            chk($sformatf("t3_level_%0d", i), 32'(lvl_a), 32'(i + 1));
        end
        if_a.frame_in = 11'h281;
        tick();
        if_a.frame_valid = 1'b0;
        chk("t3_overrun", 32'(ovr_a), 32'd1);
        chk("t3_ovr_ok", 32'(ok_a), 32'd0);
        chk("t3_ocnt", 32'(ocnt_a), 32'd1);
        chk("t3_full_level", 32'(lvl_a), 32'd4);
        tick();
        chk("t3_ovr_pulse_end", 32'(ovr_a), 32'd0);
        chk("t3_head", 32'(if_a.data_out), 32'(fill_data[0]));

        // Test 4: full FIFO with simultaneous pop and good push of 0x55
        if_a.frame_in = 11'h2A9; if_a.frame_valid = 1'b1; if_a.data_ready = 1'b1;
        tick();
        if_a.frame_valid = 1'b0; if_a.data_ready = 1'b0;
        chk("t4_level", 32'(lvl_a), 32'd4);
        chk("t4_no_ovr", 32'(ovr_a), 32'd0);
        chk("t4_ok", 32'(ok_a), 32'd1);
        chk("t4_ocnt", 32'(ocnt_a), 32'd1);
        chk("t4_head", 32'(if_a.data_out), 32'h02);
        if_a.data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_drain_%0d", i), 32'(if_a.data_out), 32'(drain_data[i]));
            tick();
        end
        if_a.data_ready = 1'b0;
        chk("t4_empty_level", 32'(lvl_a), 32'd0);
        chk("t4_empty_valid", 32'(if_a.data_valid), 32'd0);

        // Test 5: 2-bit parity counter saturates, clear beats a new error
        if_b.frame_in = 11'h297; if_b.frame_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t5_pcnt_%0d", i), 32'(pcnt_b), 32'(sat_exp[i]));
        end
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0; if_b.frame_valid = 1'b0;
        chk("t5_clr_wins", 32'(pcnt_b), 32'd0);

        // Test 6: reset mid-operation with a frame present
        for (int i = 0; i < 3; i++) begin
            if_a.frame_in = fill_frames[i]; if_a.frame_valid = 1'b1;
            tick();
        end
        if_a.frame_valid = 1'b0;
        chk("t6_pre_level", 32'(lvl_a), 32'd3);
        if_a.frame_in = 11'h295; if_a.frame_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; if_a.frame_valid = 1'b0;
        chk("t6_level", 32'(lvl_a), 32'd0);
        chk("t6_valid", 32'(if_a.data_valid), 32'd0);
        chk("t6_data", 32'(if_a.data_out), 32'h00);
        chk("t6_pcnt", 32'(pcnt_a), 32'd0);
        chk("t6_fcnt", 32'(fcnt_a), 32'd0);
        chk("t6_ocnt", 32'(ocnt_a), 32'd0);
        chk("t6_ok", 32'(ok_a), 32'd0);
        tick();
        chk("t6_ignored_level", 32'(lvl_a), 32'd0);

        // Odd parity instance accepts 0x297
        if_c.frame_in = 11'h297; if_c.frame_valid = 1'b1;
        tick();
        if_c.frame_valid = 1'b0;
        chk("t6_odd_valid", 32'(if_c.data_valid), 32'd1);
        chk("t6_odd_data", 32'(if_c.data_out), 32'hA5);
        chk("t6_odd_ok", 32'(ok_c), 32'd1);
        chk("t6_odd_perr", 32'(perr_c), 32'd0);
        chk("t6_odd_level", 32'(lvl_c), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
Parametrised UART frame checker and decoder. It takes a fully shifted-in serial frame from the receive shifter. It checks the start bit, the parity bit and the stop bit(s), and reassembles the data word in LSB-first order. Good words are pushed into a small first-word-fall-through FIFO with a valid/ready output handshake. Per-frame status pulses and saturating error/overrun counters feed the status/LED logic downstream.

Parameters:
DATA_W, 8, data bits per frame (5..9)
PARITY, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)
FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2
CNT_W, 8, width of each error/overrun counter
FRAME_W, 1+DATA_W+(PARITY!=0)+STOP_BITS, derived; do not override

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_in  in  FRAME_W  captured frame, first-received bit at MSB
frame_valid  in  1  one-cycle strobe: frame_in is complete
data_out  out  DATA_W  FIFO head word, LSB = first data bit received
data_valid  out  1  FIFO not empty
data_ready  in  1  consumer accepts data_out this cycle
fifo_level  out  clog2(FIFO_DEPTH)+1  current entry count
frame_ok  out  1  pulse: last frame was good and was stored
parity_err  out  1  pulse: last frame failed parity
framing_err  out  1  pulse: last frame had a bad start or stop bit
overrun  out  1  pulse: last frame was good but dropped because the FIFO was full
parity_cnt  out  CNT_W  saturating count of parity errors
framing_cnt  out  CNT_W  saturating count of framing errors
overrun_cnt  out  CNT_W  saturating count of overruns
clr_cnt  in  1  synchronous clear of the three counters

Behaviour:
- Frame layout, MSB to LSB:
  - start bit (expected 0)
  - d0..d(DATA_W-1)
  - parity bit, if PARITY != 0
  - STOP_BITS stop bits (expected 1)
  - Example, DATA_W=8, even parity, 1 stop: b10 = start, b9 = d0 … b2 = d7, b1 = parity, b0 = stop.
- Parity:
  - Even: XOR of the data bits must equal the parity bit.
  - Odd: XOR of the data bits must equal the inverted parity bit.
  - None: no parity check.
- Checks are combinational on frame_in. All results are registered on the clk edge where frame_valid=1. frame_in is ignored when frame_valid=0.
- framing_err = (start bit != 0) OR (any stop bit != 1).
- parity_err is evaluated independently of framing_err, so both pulses may assert for the same frame.
- Good frame: no framing error and no parity error.
  - Written to the FIFO at that same edge, unless the FIFO is full and no pop occurs in that cycle.
  - Latency: data_valid is high the cycle after frame_valid (1 cycle) when the FIFO was empty.
- Bad frames are never written to the FIFO.
- Status pulses (frame_ok, parity_err, framing_err, overrun):
  - Each is high for exactly one cycle, the cycle after frame_valid.
  - At most one of frame_ok and overrun asserts per frame.
- FIFO:
  - Pop happens when data_valid & data_ready.
  - data_out = head entry. data_out is held stable while data_valid=1 and data_ready=0.
  - data_out is don't-care when the FIFO is empty.
  - Full and pop in the same cycle: push is accepted, level unchanged.
  - Empty and push in the same cycle: level goes to 1; data_ready is ignored that cycle.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - fifo_level is always exact.
- Counters:
  - Each increments by 1 per event and saturates at 2^CNT_W-1.
  - clr_cnt zeroes all three. An event in the same cycle as clr_cnt is lost, because clear wins.
- Reset, including mid-operation:
  - FIFO emptied; data_valid=0 and fifo_level=0.
  - All pulses 0, all counters 0, data_out=0.
  - A frame_valid asserted together with rst is ignored.
- Back-to-back frame_valid on consecutive cycles must be supported with no loss while the FIFO has space.

Test Plan:
1. Reset, then frame_in=0x295 with frame_valid for 1 cycle (DATA_W=8, even parity, 1 stop) -> next cycle: data_valid=1, data_out=0xA5, frame_ok=1, fifo_level=1; pop -> fifo_level=0.
2. frame_in=0x297 (parity bit flipped) -> parity_err=1, framing_err=0, parity_cnt=1, FIFO unchanged. Then 0x294 (stop=0) and 0x695 (start=1) -> framing_cnt=2, no writes.
3. data_ready=0, send 5 good frames 0x01..0x05 (FIFO_DEPTH=4) -> fifo_level=4; 5th frame gives overrun=1 and overrun_cnt=1. Draining yields 0x01,0x02,0x03,0x04 in order.
4. FIFO full, with data_ready=1 and frame_valid (good, 0x55) in the same cycle -> 0x01 popped, 0x55 stored, fifo_level stays 4, no overrun.
5. CNT_W=2, four parity errors -> parity_cnt=3 (saturated). clr_cnt together with a fifth error -> parity_cnt=0.
6. rst asserted while fifo_level=3 and a frame_valid is present -> next cycle: fifo_level=0, data_valid=0, all counters and pulses 0. Repeat test 1 with PARITY=2 using frame 0x297 -> accepted, data_out=0xA5.
